// File: rtl/beep_burst_gen.sv
// beep_burst_gen: buzzer driver. Each accepted trigger plays BURSTS square-wave
// tone bursts of ON_CYCLES each, separated by OFF_CYCLES of silence. It raises
// busy for the whole sequence and pulses done once when the sequence completes.
module beep_burst_gen #(
    parameter int HALF_PERIOD = 25_000,
    parameter int ON_CYCLES   = 5_000_000,
    parameter int OFF_CYCLES  = 5_000_000,
    parameter int BURSTS      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic trig,
    output logic beep,
    output logic busy,
    output logic done
);

    // One duration counter is shared by bursts and gaps, so it is sized for the longer of the two.
    localparam int DMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int TW   = $clog2(HALF_PERIOD + 1);
    localparam int BW   = $clog2(BURSTS + 1);

    localparam logic [DW-1:0] ON_LAST  = DW'(ON_CYCLES - 1);
    localparam logic [DW-1:0] OFF_LAST = DW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BURSTS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   dur_cnt, dur_n;
    logic [TW-1:0]   tone_cnt, tone_n;
    logic [BW-1:0]   burst_idx, burst_n;
    logic            beep_n, busy_n, done_n;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        dur_n   = dur_cnt;
        tone_n  = tone_cnt;
        burst_n = burst_idx;
        beep_n  = beep;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                beep_n = 1'b0;
                busy_n = 1'b0;
                if (trig) begin
                    state_n = ON;
                    dur_n   = '0;
                    tone_n  = '0;
                    burst_n = '0;
                    beep_n  = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ON: begin
                dur_n = dur_cnt + DW'(1);
                if (tone_cnt == HP_LAST) begin
                    beep_n = ~beep;
                    tone_n = '0;
                end else begin
                    tone_n = tone_cnt + TW'(1);
                end
                // End of burst wins over the tone toggle: a partial half-period is cut off.
                if (dur_cnt == ON_LAST) begin
                    beep_n = 1'b0;
                    dur_n  = '0;
                    tone_n = '0;
                    if (burst_idx == B_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        burst_n = '0;
                    end else begin
                        state_n = OFF;
                    end
                end
            end
            OFF: begin
                beep_n = 1'b0;
                busy_n = 1'b1;
                dur_n  = dur_cnt + DW'(1);
                if (dur_cnt == OFF_LAST) begin
                    state_n = ON;
                    burst_n = burst_idx + BW'(1);
                    dur_n   = '0;
                    tone_n  = '0;
                    beep_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset and disable both force a silent idle.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            state     <= IDLE;
            dur_cnt   <= '0;
            tone_cnt  <= '0;
            burst_idx <= '0;
            beep      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            dur_cnt   <= dur_n;
            tone_cnt  <= tone_n;
            burst_idx <= burst_n;
            beep      <= beep_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_beep_burst_gen.sv
// tb_beep_burst_gen: three differently parameterised instances share stimulus;
// a sequence-offset model predicts beep/busy/done and is compared every cycle.
module tb_beep_burst_gen;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic trig = 1'b0;
    logic [N-1:0] beep, busy, done;

    int hp_a[N]  = '{2, 3, 9};
    int on_a[N]  = '{8, 7, 3};
    int off_a[N] = '{4, 3, 2};
    int b_a[N]   = '{2, 1, 3};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    beep_burst_gen #(.HALF_PERIOD(2), .ON_CYCLES(8), .OFF_CYCLES(4), .BURSTS(2)) u0 (
        .clk(clk), .rst(rst), .en(en), .trig(trig),
        .beep(beep[0]), .busy(busy[0]), .done(done[0]));
    beep_burst_gen #(.HALF_PERIOD(3), .ON_CYCLES(7), .OFF_CYCLES(3), .BURSTS(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .trig(trig),
        .beep(beep[1]), .busy(busy[1]), .done(done[1]));
    beep_burst_gen #(.HALF_PERIOD(9), .ON_CYCLES(3), .OFF_CYCLES(2), .BURSTS(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .trig(trig),
        .beep(beep[2]), .busy(busy[2]), .done(done[2]));

    // Model: a running sequence is just an offset k into a fixed-length timeline.
    int k[N];
    bit act[N];
    bit mdone[N];

    function automatic int seq_len(int i);
        return b_a[i] * on_a[i] + (b_a[i] - 1) * off_a[i];
    endfunction

    function automatic bit m_beep(int i);
        int r;
        if (!act[i]) return 1'b0;
        r = k[i] % (on_a[i] + off_a[i]);
        return (r < on_a[i]) && (((r / hp_a[i]) % 2) == 0);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst || !en) begin
                act[i] = 1'b0;
                mdone[i] = 1'b0;
                k[i] = 0;
            end else if (act[i]) begin
                k[i] = k[i] + 1;
                if (k[i] == seq_len(i)) begin
                    act[i] = 1'b0;
                    mdone[i] = 1'b1;
                end
            end else begin
                mdone[i] = 1'b0;
                if (trig) begin
                    act[i] = 1'b1;
                    k[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("beep[%0d]", i), int'(beep[i]), int'(m_beep(i)));
            chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(act[i]));
            chk($sformatf("done[%0d]", i), int'(done[i]), int'(mdone[i]));
        end
    end

    logic [19:0] pat0;
    logic [6:0]  pat1;

    initial begin
        pat0 = 20'b11001100_0000_11001100;
        pat1 = 7'b1110001;

        // Reset held for three edges while trig toggles.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1 trig = ~trig;
        end
        @(negedge clk);
        chk("reset_busy0", int'(busy[0]), 0);
        chk("reset_beep0", int'(beep[0]), 0);
        @(posedge clk); #1 rst = 1'b1; trig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("no_start_after_reset", int'(busy[0]), 0);

        // Basic sequence with trig pulses during the run (must be ignored by u0).
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;   // edge T sampled trig
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            if (j <= 20) begin
                chk($sformatf("model0_beep_T+%0d", j), int'(m_beep(0)), int'(pat0[20-j]));
                chk($sformatf("dut0_beep_T+%0d", j), int'(beep[0]), int'(pat0[20-j]));
                chk($sformatf("dut0_busy_T+%0d", j), int'(busy[0]), 1);
            end
            if (j <= 7)
                chk($sformatf("dut1_beep_T+%0d", j), int'(beep[1]), int'(pat1[7-j]));
            if (j == 8) begin
                chk("dut1_done_T+8", int'(done[1]), 1);
                chk("model1_done_T+8", int'(mdone[1]), 1);
            end
            if (j == 21) begin
                chk("dut0_done_T+21", int'(done[0]), 1);
                chk("dut0_busy_T+21", int'(busy[0]), 0);
                chk("model0_done_T+21", int'(mdone[0]), 1);
            end
            trig = (j == 5 || j == 14);
        end
        @(negedge clk);
        chk("dut0_done_T+22", int'(done[0]), 0);
        trig = 1'b0;
        repeat (30) @(posedge clk);

        // Disable for one cycle mid-sequence aborts without done.
        #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        repeat (6) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);
        chk("abort_busy0", int'(busy[0]), 0);
        chk("abort_beep0", int'(beep[0]), 0);
        repeat (25) begin
            @(negedge clk);
            chk("abort_no_done0", int'(done[0]), 0);
        end

        // Randomised traffic: triggers, occasional disable and reset.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            trig = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 79) != 0);
            rst  = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk); #1 trig = 1'b0; en = 1'b1; rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
